// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 8x16 LED matrix: geometry, drive-word layout and colour codes.
// Used by the frame scanner and by the bar/ball game logic.
package led_matrix_pkg;

    localparam int MATRIX_W      = 8;
    localparam int MATRIX_H      = 16;
    localparam int PIX_COUNT     = MATRIX_W * MATRIX_H;
    localparam int X_W           = $clog2(MATRIX_W);
    localparam int Y_W           = $clog2(MATRIX_H);
    localparam int IDX_W         = X_W + Y_W;
    localparam int COLOR_W       = 3;
    localparam int LED_W         = COLOR_W + IDX_W;
    localparam int LED_COL_LSB   = 0;
    localparam int LED_ROW_LSB   = X_W;
    localparam int LED_COLOR_LSB = X_W + Y_W;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(PIX_COUNT - 1);
    localparam logic [COLOR_W-1:0] COLOR_OFF   = 3'b000;
    localparam logic [COLOR_W-1:0] COLOR_BLUE  = 3'b001;
    localparam logic [COLOR_W-1:0] COLOR_GREEN = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_RED   = 3'b100;

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } clr_state_t;

    // Dark pixels drive an all-zero word so the shared driver idles between lit pixels.
    function automatic logic [LED_W-1:0] led_word(input logic [COLOR_W-1:0] color,
                                                  input logic [IDX_W-1:0]   idx);
        logic [LED_W-1:0] word;
        word = '0;
        if (color != COLOR_OFF) begin
            word[LED_COLOR_LSB +: COLOR_W] = color;
            word[LED_ROW_LSB +: Y_W]       = idx[IDX_W-1:X_W];
            word[LED_COL_LSB +: X_W]       = idx[X_W-1:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/matrix_frame_scanner_if.sv
// Pixel write / clear / swap handshake and LED drive outputs of the frame scanner.
interface matrix_frame_scanner_if;
    import led_matrix_pkg::*;

    logic               wr_en;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [COLOR_W-1:0] wr_color;
    logic               wr_ready;
    logic               clr_req;
    logic               swap_req;
    logic               swap_ack;
    logic               frame_start;
    logic [LED_W-1:0]   LEDout;

    modport master (
        output wr_en, wr_x, wr_y, wr_color, clr_req, swap_req,
        input  wr_ready, swap_ack, frame_start, LEDout
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_color, clr_req, swap_req,
        output wr_ready, swap_ack, frame_start, LEDout
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high on the cycle the count equals DIV-1, then wraps to 0.
module tick_gen #(
    parameter logic [21:0] DIV = 22'd2000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    logic [21:0] r_cnt;

    assign tick = (r_cnt == DIV - 22'd1);

    always_ff @(posedge CLK) begin
        if (RST)       r_cnt <= '0;
        else if (tick) r_cnt <= '0;
        else           r_cnt <= r_cnt + 22'd1;
    end

endmodule

// File: rtl/matrix_frame_scanner.sv
// Scans a 128-pixel colour buffer onto the shared LED driver, one pixel per SCAN_DIV cycles.
// MATRIX_DOUBLE_BUF_EN adds a back buffer swapped in at the frame wrap.
//
// state       | meaning
// ST_IDLE     | writes accepted, clr_req starts a clear
// ST_CLEARING | writing 000 to one pixel per cycle, writes refused
module matrix_frame_scanner
    import led_matrix_pkg::*;
#(
    parameter logic [21:0] SCAN_DIV = 22'd2000
) (
    input  logic CLK,
    input  logic RST,
    matrix_frame_scanner_if.slave bus
);

    logic               w_tick;
    logic               w_wrap;
    logic               w_swap;
    logic               w_we;
    logic [IDX_W-1:0]   w_idx_next;
    logic [IDX_W-1:0]   w_waddr;
    logic [COLOR_W-1:0] w_wdata;
    logic [COLOR_W-1:0] w_rd_color;

    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_clr_idx;
    logic [LED_W-1:0]   r_led;
    logic               r_frame_start;
    logic               r_swap_ack;
    logic               r_wr_ready;
    clr_state_t         r_state;

    tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    assign w_idx_next = r_idx + 1'b1;
    assign w_wrap     = w_tick && (r_idx == LAST_IDX);
    assign w_we       = (bus.wr_en && r_wr_ready) || (r_state == ST_CLEARING);
    assign w_waddr    = (r_state == ST_CLEARING) ? r_clr_idx : {bus.wr_y, bus.wr_x};
    assign w_wdata    = (r_state == ST_CLEARING) ? COLOR_OFF : bus.wr_color;

`ifdef MATRIX_DOUBLE_BUF_EN
    logic [COLOR_W-1:0] r_mem [2][PIX_COUNT];
    logic               r_front;
    logic               r_swap_pend;
    logic               w_rd_buf;

    // A swap waits for an idle clear FSM so a half-cleared buffer is never shown.
    assign w_swap     = w_wrap && r_swap_pend && (r_state == ST_IDLE);
    assign w_rd_buf   = w_swap ? ~r_front : r_front;
    assign w_rd_color = r_mem[w_rd_buf][w_idx_next];

    always_ff @(posedge CLK) begin
        if (!RST && w_we) r_mem[~r_front][w_waddr] <= w_wdata;
    end
`else
    logic [COLOR_W-1:0] r_mem [PIX_COUNT];

    assign w_swap     = 1'b0;
    assign w_rd_color = r_mem[w_idx_next];

    always_ff @(posedge CLK) begin
        if (!RST && w_we) r_mem[w_waddr] <= w_wdata;
    end
`endif

    // Read and write share an edge, so a same-cycle hit sees the old colour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx         <= '0;
            r_led         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_idx <= w_idx_next;
                r_led <= led_word(w_rd_color, w_idx_next);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b1;
            r_clr_idx  <= '0;
            r_swap_ack <= 1'b0;
`ifdef MATRIX_DOUBLE_BUF_EN
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state    <= ST_CLEARING;
                        r_wr_ready <= 1'b0;
                        r_clr_idx  <= '0;
                    end
                end
                ST_CLEARING: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state    <= ST_IDLE;
                        r_wr_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef MATRIX_DOUBLE_BUF_EN
            r_swap_ack <= w_swap;
            if (w_swap) begin
                r_front     <= ~r_front;
                r_swap_pend <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pend <= 1'b1;
            end
`else
            r_swap_ack <= bus.swap_req;
`endif
        end
    end

    assign bus.wr_ready    = r_wr_ready;
    assign bus.swap_ack    = r_swap_ack;
    assign bus.frame_start = r_frame_start;
    assign bus.LEDout      = r_led;

endmodule

// File: doc/matrix_frame_scanner.md
MATRIX_FRAME_SCANNER -- requirements
Module: matrix_frame_scanner

Interface
REQ-001 The block SHALL have the parameter SCAN_DIV, default 22'd2000, giving clock cycles per displayed pixel slot; legal range 2..2^22-1.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single system clock.
REQ-003 The block SHALL have the port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port wr_en, input, 1 bit: pixel write strobe.
REQ-005 The block SHALL have the ports wr_x, input, 3 bits, and wr_y, input, 4 bits: pixel column 0..7 and row 0..15.
REQ-006 The block SHALL have the port wr_color, input, 3 bits: pixel colour code, where 000 means off.
REQ-007 The block SHALL have the port wr_ready, output, 1 bit: writes accepted; low while a clear is running.
REQ-008 The block SHALL have the port clr_req, input, 1 bit: start a clear of the write buffer.
REQ-009 The block SHALL have the ports swap_req, input, 1 bit, and swap_ack, output, 1 bit: buffer swap handshake.
REQ-010 The block SHALL have the port frame_start, output, 1 bit: one-cycle pulse when the scan restarts at pixel 0.
REQ-011 The block SHALL have the port LEDout, output, 10 bits: drive word {color[2:0], row[3:0], col[2:0]} for the shared LED matrix/colour driver.

Function
REQ-012 Storage SHALL be 128 pixels × 3 bits, indexed {y,x}.
REQ-013 A write with wr_en=1 and wr_ready=1 SHALL update the write buffer at the next clock edge.
REQ-014 While wr_ready=0, wr_en SHALL be ignored.
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is the cycle on which it equals SCAN_DIV-1.
REQ-016 On each tick, scan index SHALL advance modulo 128 (127 -> 0).
REQ-017 LEDout SHALL be registered and updated the cycle after the tick from the display buffer at the new index.
REQ-018 LEDout SHALL be {color,y,x} if color != 000, else 10'b0.
REQ-019 frame_start SHALL pulse for one cycle, in the same cycle that the 127 -> 0 index wrap is registered.
REQ-020 If a write and a scan read hit the same pixel in the same cycle, the scan SHALL see the old value.
REQ-021 clr_req=1 with wr_ready=1 SHALL drop wr_ready the next cycle.
REQ-022 The clear SHALL write 000 to the write buffer at one pixel per cycle for 128 cycles, ascending index.
REQ-023 wr_ready SHALL return high the cycle after pixel 127 is cleared.
REQ-024 clr_req while a clear is running SHALL be ignored.
REQ-025 Clear state machine SHALL have exactly the states IDLE and CLEARING.
REQ-026 Scanning SHALL continue unaffected during a clear.

Reset
REQ-027 RST=1 at a clock edge SHALL set prescaler=0, scan index=0, LEDout=0, frame_start=0, swap_ack=0, wr_ready=1, clear FSM=IDLE, swap pending=0, front buffer select=0.
REQ-028 Pixel storage SHALL NOT be reset.
REQ-029 RST during a clear SHALL abort the clear, leaving partially cleared contents.

Configuration
REQ-030 With macro MATRIX_DOUBLE_BUF_EN defined, two 128-pixel buffers SHALL exist; writes and clears target the back buffer and scanning reads the front buffer.
REQ-031 With MATRIX_DOUBLE_BUF_EN defined, swap_req=1 SHALL set swap pending; swap_req while already pending has no further effect.
REQ-032 With MATRIX_DOUBLE_BUF_EN defined, the swap SHALL occur only at the 127 -> 0 wrap tick: buffers are exchanged, swap_ack pulses one cycle together with frame_start, and pending clears.
REQ-033 With MATRIX_DOUBLE_BUF_EN defined, a swap_req while a clear is running SHALL stay pending until the clear completes and the next wrap tick occurs.
REQ-034 Without MATRIX_DOUBLE_BUF_EN, one buffer SHALL exist, writes SHALL be visible on the next scan of that pixel, and swap_ack SHALL pulse one cycle after every swap_req cycle.

Structure
REQ-035 Shared package led_matrix_pkg SHALL hold matrix width 8, height 16, pixel count 128, LEDout field positions, and colour codes (OFF=000); the bar/ball game logic uses the same package.
REQ-036 The prescaler SHALL be sub-module tick_gen (parameter DIV; output tick), reused by the game logic.

Verification
REQ-037 Bench SHALL check reset with SCAN_DIV=4: after RST, LEDout=0, wr_ready=1, and the first tick at cycle 3 gives index 1.
REQ-038 Bench SHALL check write/scan: write (x=2,y=12,color=100) with no macro -> when index reaches 98, LEDout=10'b1001100010; a blank pixel gives 0.
REQ-039 Bench SHALL check clear: clr_req on cycle N -> wr_ready=0 for cycles N+1..N+128, high at N+129; a wr_en inside that window is dropped; all pixels read 000.
REQ-040 Bench SHALL check wrap: with SCAN_DIV=4, frame_start pulses every 512 cycles, aligned with index 0.
REQ-041 Bench SHALL check double buffer: with MATRIX_DOUBLE_BUF_EN, write pixel 5 = 010 and confirm the front stays 000; swap_req mid-frame -> swap_ack coincides with the next frame_start; pixel 5 then shows 10'b0100000101.
REQ-042 Bench SHALL check same-cycle conflict: a write to pixel k in the cycle of its scan read -> old colour shown, new colour shown on the next frame.
